// File: rtl/hslp_mul_iter_pkg.sv
// Shared definitions for the iterative HSLP approximate multiplier:
// quadrant mode codes, FSM state encoding, cfg field layout and the
// quadrant-sequencing helper used by the controller.
package hslp_mul_iter_pkg;

  localparam int unsigned CFG_W    = 8;
  localparam int unsigned MODE_W   = 2;
  localparam int unsigned NUM_QUAD = 4;

  // Bit offsets of each quadrant's mode field inside cfg
  localparam int unsigned CFG_LL_OFS = 0;
  localparam int unsigned CFG_LH_OFS = 2;
  localparam int unsigned CFG_HL_OFS = 4;
  localparam int unsigned CFG_HH_OFS = 6;

  typedef enum logic [1:0] {
    MODE_EXACT = 2'd0,
    MODE_TRUNC = 2'd1,
    MODE_SKIP  = 2'd2,
    MODE_RSVD  = 2'd3   // treated as exact
  } mode_e;

  // Quadrant states are numbered so that state value == quadrant index + 1
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LL   = 3'd1,
    LH   = 3'd2,
    HL   = 3'd3,
    HH   = 3'd4,
    DONE = 3'd5
  } state_e;

  // Mode of quadrant q (0=LL, 1=LH, 2=HL, 3=HH)
  function automatic mode_e quad_mode(input logic [CFG_W-1:0] cfg, input int unsigned q);
    return mode_e'(cfg[q*MODE_W +: MODE_W]);
  endfunction

  // First non-skipped quadrant with index >= from, or DONE if none remain
  function automatic state_e next_quad(input logic [CFG_W-1:0] cfg, input int unsigned from);
    state_e s;
    logic   found;
    s     = DONE;
    found = 1'b0;
    for (int unsigned q = 0; q < NUM_QUAD; q++) begin
      if (!found && q >= from && quad_mode(cfg, q) != MODE_SKIP) begin
        s     = state_e'(3'(q + 1));
        found = 1'b1;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/hslp_mul_iter_if.sv
// Operand/result handshake bundle for hslp_mul_iter.
//   in_valid/in_ready, in_a, in_b, in_cfg : operand request channel
//   out_valid/out_ready, out_prod         : result channel
// master = operand source / result consumer, slave = the multiplier.
interface hslp_mul_iter_if
  import hslp_mul_iter_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [CFG_W-1:0]     in_cfg;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_prod;

  modport master (
    output in_valid, in_a, in_b, in_cfg, out_ready,
    input  in_ready, out_valid, out_prod
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cfg, out_ready,
    output in_ready, out_valid, out_prod
  );

endinterface

// File: rtl/hslp_mul_iter_submul.sv
// Combinational HW x HW unsigned sub-multiplier shared by all quadrants.
//   a, b   : half-width operands
//   trunc  : drop partial-product bits in columns i+j < TRUNC
//   prod_c : exact or column-truncated product
module hslp_mul_iter_submul #(
  parameter int unsigned HW    = 8,
  parameter int unsigned TRUNC = HW / 2
) (
  input  logic [HW-1:0]   a,
  input  logic [HW-1:0]   b,
  input  logic            trunc,
  output logic [2*HW-1:0] prod_c
);

  // Sum of the kept partial-product bits
  always_comb begin
    prod_c = '0;
    for (int unsigned i = 0; i < HW; i++) begin
      for (int unsigned j = 0; j < HW; j++) begin
        if (a[i] && b[j] && (!trunc || (i + j) >= TRUNC)) begin
          prod_c = prod_c + ((2*HW)'(1) << (i + j));
        end
      end
    end
  end

endmodule

// File: rtl/hslp_mul_iter.sv
// Iterative hybrid split-level approximate multiplier. Forms the four
// half-width sub-products one per cycle on one shared sub-multiplier and
// accumulates them; each quadrant is exact, truncated or skipped per cfg.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : operand/result valid-ready channel (slave side)
//   busy       : high whenever the controller is not idle
module hslp_mul_iter
  import hslp_mul_iter_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TRUNC = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  hslp_mul_iter_if.slave   bus,
  output logic             busy
);

  localparam int unsigned HW = WIDTH / 2;
  localparam int unsigned PW = 2 * WIDTH;

  state_e           state, state_n;
  logic [WIDTH-1:0] a_q, a_n, b_q, b_n;
  logic [CFG_W-1:0] cfg_q, cfg_n;
  logic [PW-1:0]    acc_q, acc_n;
  logic             in_ready_q, out_valid_q;

  logic             in_quad, a_hi, b_hi, sub_trunc;
  int unsigned      qidx, shamt;
  logic [HW-1:0]    sub_a, sub_b;
  logic [WIDTH-1:0] sub_p;

  hslp_mul_iter_submul #(.HW(HW), .TRUNC(TRUNC)) u_submul (
    .a      (sub_a),
    .b      (sub_b),
    .trunc  (sub_trunc),
    .prod_c (sub_p)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_prod  = acc_q;

  // Next-state, operand routing and accumulation
  always_comb begin
    state_n   = state;
    a_n       = a_q;
    b_n       = b_q;
    cfg_n     = cfg_q;
    acc_n     = acc_q;
    in_quad   = 1'b0;
    a_hi      = 1'b0;
    b_hi      = 1'b0;
    qidx      = 0;
    shamt     = 0;
    sub_a     = '0;
    sub_b     = '0;
    sub_trunc = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          a_n     = bus.in_a;
          b_n     = bus.in_b;
          cfg_n   = bus.in_cfg;
          acc_n   = '0;
          state_n = next_quad(bus.in_cfg, 0);
        end
      end
      LL: begin in_quad = 1'b1; qidx = 0; end
      LH: begin in_quad = 1'b1; qidx = 1; b_hi = 1'b1; shamt = HW; end
      HL: begin in_quad = 1'b1; qidx = 2; a_hi = 1'b1; shamt = HW; end
      HH: begin in_quad = 1'b1; qidx = 3; a_hi = 1'b1; b_hi = 1'b1; shamt = WIDTH; end
      DONE: begin
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (in_quad) begin
      sub_a     = a_hi ? a_q[WIDTH-1:HW] : a_q[HW-1:0];
      sub_b     = b_hi ? b_q[WIDTH-1:HW] : b_q[HW-1:0];
      sub_trunc = (quad_mode(cfg_q, qidx) == MODE_TRUNC);
      acc_n     = acc_q + (PW'(sub_p) << shamt);
      state_n   = next_quad(cfg_q, qidx + 1);
    end
  end

  // State and datapath registers; handshake flags follow the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cfg_q       <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      a_q         <= a_n;
      b_q         <= b_n;
      cfg_q       <= cfg_n;
      acc_q       <= acc_n;
      in_ready_q  <= (state_n == IDLE);
      out_valid_q <= (state_n == DONE);
      busy        <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_hslp_mul_iter.sv
// Bench for hslp_mul_iter: directed 8-bit cases (TRUNC=2) and randomized
// 16-bit traffic against an arithmetic reference of the truncated/skip sum.
module tb_hslp_mul_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy8, busy16;
  int   ntests = 0;
  int   nfail  = 0;

  hslp_mul_iter_if #(.WIDTH(8))  i8 ();
  hslp_mul_iter_if #(.WIDTH(16)) i16 ();

  hslp_mul_iter #(.WIDTH(8), .TRUNC(2)) u8 (
    .clk (clk), .rst_n (rst_n), .bus (i8), .busy (busy8)
  );

  hslp_mul_iter #(.WIDTH(16)) u16 (
    .clk (clk), .rst_n (rst_n), .bus (i16), .busy (busy16)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // x*y with partial-product bits in columns < t removed
  function automatic logic [63:0] trunc_mul(input logic [63:0] x, input logic [63:0] y, input int t);
    logic [63:0] p;
    p = x * y;
    for (int i = 0; i < t; i++)
      if (x[i]) p = p - ((y & ((64'd1 << (t - i)) - 64'd1)) << i);
    return p;
  endfunction

  function automatic logic [63:0] ref_prod(input logic [63:0] a, input logic [63:0] b,
                                           input logic [7:0] cfg, input int hw, input int t,
                                           output int k);
    logic [63:0] m, acc, term;
    logic [63:0] xs [4];
    logic [63:0] ys [4];
    int          sh [4];
    int          md;
    m     = (64'd1 << hw) - 64'd1;
    xs[0] = a & m;         ys[0] = b & m;         sh[0] = 0;
    xs[1] = a & m;         ys[1] = (b >> hw) & m; sh[1] = hw;
    xs[2] = (a >> hw) & m; ys[2] = b & m;         sh[2] = hw;
    xs[3] = (a >> hw) & m; ys[3] = (b >> hw) & m; sh[3] = 2 * hw;
    acc = 0;
    k   = 0;
    for (int q = 0; q < 4; q++) begin
      md = int'((cfg >> (2 * q)) & 8'd3);
      if (md != 2) begin
        k++;
        term = (md == 1) ? trunc_mul(xs[q], ys[q], t) : xs[q] * ys[q];
        acc  = acc + (term << sh[q]);
      end
    end
    return acc;
  endfunction

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] cfg);
    @(negedge clk);
    i8.in_a = a; i8.in_b = b; i8.in_cfg = cfg; i8.in_valid = 1'b1;
    @(posedge clk); #1;
    i8.in_valid = 1'b0;
  endtask

  // Cycles from the accept edge until out_valid, bounded
  task automatic wait8(output int lat, output bit busy_all);
    lat = 0;
    busy_all = 1'b1;
    while (!i8.out_valid && lat < 20) begin
      if (!busy8) busy_all = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (!busy8) busy_all = 1'b0;
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] cfg, input logic [63:0] exp, input int exp_lat);
    int lat;
    bit ba;
    start8(a, b, cfg);
    wait8(lat, ba);
    check({tag, "_prod"}, 64'(i8.out_prod), exp);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy"}, 64'(ba), 64'd1);
    @(posedge clk); #1;
    check({tag, "_inready"}, 64'(i8.in_ready), 64'd1);
    check({tag, "_outvalid"}, 64'(i8.out_valid), 64'd0);
    check({tag, "_retain"}, 64'(i8.out_prod), exp);
  endtask

  initial begin
    int          lat, k;
    bit          ba;
    logic [63:0] exp;
    logic [15:0] ra, rb;
    logic [7:0]  rc;

    i8.in_valid = 1'b0;  i8.in_a = '0;  i8.in_b = '0;  i8.in_cfg = '0;  i8.out_ready = 1'b1;
    i16.in_valid = 1'b0; i16.in_a = '0; i16.in_b = '0; i16.in_cfg = '0; i16.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_inready", 64'(i8.in_ready), 64'd1);
    check("rst_outvalid", 64'(i8.out_valid), 64'd0);
    check("rst_prod", 64'(i8.out_prod), 64'd0);
    check("rst_busy", 64'(busy8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op8("exact", 8'd200, 8'd150, 8'h00, 64'd30000, 4);
    op8("trunc_ll", 8'h0F, 8'h0F, 8'h01, 64'd220, 4);
    op8("skip_ll", 8'hFF, 8'hFF, 8'h02, 64'd64800, 3);
    op8("skip_all", 8'hFF, 8'hFF, 8'hAA, 64'd0, 0);
    op8("rsvd", 8'hFF, 8'h11, 8'hFF, 64'd4335, 4);

    // Backpressure: result held, new requests ignored
    i8.out_ready = 1'b0;
    start8(8'd7, 8'd9, 8'h00);
    wait8(lat, ba);
    check("bp_prod", 64'(i8.out_prod), 64'd63);
    check("bp_lat", 64'(lat), 64'd4);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      i8.in_valid = 1'b1;
      i8.in_a = 8'($urandom);
      @(posedge clk); #1;
      check("bp_hold_prod", 64'(i8.out_prod), 64'd63);
      check("bp_hold_valid", 64'(i8.out_valid), 64'd1);
      check("bp_hold_inready", 64'(i8.in_ready), 64'd0);
    end
    @(negedge clk);
    i8.in_valid = 1'b0;
    i8.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 64'(i8.out_valid), 64'd0);
    check("bp_release_inready", 64'(i8.in_ready), 64'd1);
    check("bp_release_busy", 64'(busy8), 64'd0);
    check("bp_release_prod", 64'(i8.out_prod), 64'd63);

    // Reset while the LH quadrant is being formed
    start8(8'hAB, 8'hCD, 8'h00);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_inready", 64'(i8.in_ready), 64'd1);
    check("midrst_outvalid", 64'(i8.out_valid), 64'd0);
    check("midrst_prod", 64'(i8.out_prod), 64'd0);
    check("midrst_busy", 64'(busy8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op8("after_rst", 8'd3, 8'd5, 8'h00, 64'd15, 4);

    // Randomized 16-bit traffic, TRUNC=4
    for (int n = 0; n < 10000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 8'($urandom);
      exp = ref_prod(64'(ra), 64'(rb), rc, 8, 4, k);
      @(negedge clk);
      i16.in_a = ra; i16.in_b = rb; i16.in_cfg = rc; i16.in_valid = 1'b1;
      @(posedge clk); #1;
      i16.in_valid = 1'b0;
      lat = 0;
      while (!i16.out_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      check("rand_prod", 64'(i16.out_prod), exp);
      check("rand_lat", 64'(lat), 64'(k));
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
